// File: rtl/simple_pkg.sv
// Shared encodings for the phase sequencer: states, opcode fields, branch
// conditions, CCR bit positions and the instruction-class decoder.
package simple_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_P1   = 3'd1,
        ST_P2   = 3'd2,
        ST_P3   = 3'd3,
        ST_P4   = 3'd4,
        ST_P5   = 3'd5,
        ST_HALT = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        CL_NOP, CL_ALU, CL_CMP, CL_IN, CL_OUT, CL_HLT, CL_LW,
        CL_ST, CL_LI, CL_ADDI, CL_SUBI, CL_B, CL_BCC
    } iclass_t;

    localparam logic [3:0] OP3_ADD = 4'b0000;
    localparam logic [3:0] OP3_SUB = 4'b0001;
    localparam logic [3:0] OP3_ADC = 4'b0010;
    localparam logic [3:0] OP3_SBC = 4'b0011;
    localparam logic [3:0] OP3_AND = 4'b0100;
    localparam logic [3:0] OP3_CMP = 4'b0101;
    localparam logic [3:0] OP3_OR  = 4'b0110;
    localparam logic [3:0] OP3_XOR = 4'b0111;
    localparam logic [3:0] OP3_SLL = 4'b1000;
    localparam logic [3:0] OP3_SLR = 4'b1001;
    localparam logic [3:0] OP3_SRL = 4'b1010;
    localparam logic [3:0] OP3_SRA = 4'b1011;
    localparam logic [3:0] OP3_IN  = 4'b1100;
    localparam logic [3:0] OP3_OUT = 4'b1101;
    localparam logic [3:0] OP3_HLT = 4'b1111;

    localparam logic [1:0] OP2_LW  = 2'b00;
    localparam logic [1:0] OP2_ST  = 2'b01;
    localparam logic [1:0] OP2_IMM = 2'b10;
    localparam logic [1:0] OP2_ALU = 2'b11;

    localparam logic [4:0] OPC_LI   = 5'b10000;
    localparam logic [4:0] OPC_ADDI = 5'b10001;
    localparam logic [4:0] OPC_SUBI = 5'b10010;
    localparam logic [4:0] OPC_B    = 5'b10100;
    localparam logic [4:0] OPC_BCC  = 5'b10111;

    localparam logic [2:0] COND_BE  = 3'b000;
    localparam logic [2:0] COND_BLT = 3'b001;
    localparam logic [2:0] COND_BLE = 3'b010;
    localparam logic [2:0] COND_BNE = 3'b011;

    localparam int CCR_S = 3;
    localparam int CCR_Z = 2;
    localparam int CCR_C = 1;
    localparam int CCR_V = 0;

    function automatic iclass_t decode_class(input logic [15:0] ins);
        iclass_t cls;
        cls = CL_NOP;
        case (ins[15:14])
            OP2_LW:  cls = CL_LW;
            OP2_ST:  cls = CL_ST;
            OP2_ALU: begin
                if (ins[7:4] == OP3_CMP)       cls = CL_CMP;
                else if (ins[7:4] <= OP3_SRA)  cls = CL_ALU;
                else if (ins[7:4] == OP3_IN)   cls = CL_IN;
                else if (ins[7:4] == OP3_OUT)  cls = CL_OUT;
                else if (ins[7:4] == OP3_HLT)  cls = CL_HLT;
                else                           cls = CL_NOP;
            end
            default: begin
                case (ins[15:11])
                    OPC_LI:   cls = CL_LI;
                    OPC_ADDI: cls = CL_ADDI;
                    OPC_SUBI: cls = CL_SUBI;
                    OPC_B:    cls = CL_B;
                    OPC_BCC:  cls = CL_BCC;
                    default:  cls = CL_NOP;
                endcase
            end
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/simple_br_eval.sv
// Branch resolution: decides whether a B/Bcc instruction redirects the PC
// based on the condition field and the current CCR.
module simple_br_eval
    import simple_pkg::*;
(
    input  iclass_t    cls,
    input  logic [2:0] cond,
    input  logic [3:0] ccr,
    output logic       taken
);

    logic s_flag, z_flag, v_flag;
    logic unused_carry;

    assign s_flag       = ccr[CCR_S];
    assign z_flag       = ccr[CCR_Z];
    assign v_flag       = ccr[CCR_V];
    assign unused_carry = ccr[CCR_C];

    always_comb begin
        taken = 1'b0;
        if (cls == CL_B) begin
            taken = 1'b1;
        end else if (cls == CL_BCC) begin
            // cond 1xx encodings are reserved and never taken
            case (cond)
                COND_BE:  taken = z_flag;
                COND_BLT: taken = s_flag ^ v_flag;
                COND_BLE: taken = z_flag | (s_flag ^ v_flag);
                COND_BNE: taken = ~z_flag;
                default:  taken = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/simple_phase_ctrl.sv
// Five-phase instruction sequencer with CCR and retired counter.
// Build option: define SKIP_P4_EN to bypass P4 for non-memory, non-branch classes.
module simple_phase_ctrl
    import simple_pkg::*;
#(
    parameter int RET_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [15:0]      instr,
    input  logic [3:0]       code,
    input  logic             mem_ready,
    output logic [4:0]       phase,
    output logic             ir_we,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             mem_re,
    output logic             mem_we,
    output logic             reg_we,
    output logic             out_we,
    output logic [3:0]       ccr,
    output logic             running,
    output logic             halted,
    output logic [RET_W-1:0] retired
);

    state_t           state_q, state_d;
    logic [3:0]       ccr_q, ccr_d;
    logic [RET_W-1:0] retired_q, retired_d;
    iclass_t          cls;
    logic             br_taken;
    logic             ccr_upd;
    logic             wb_reg;

    assign cls = decode_class(instr);

    simple_br_eval u_br_eval (
        .cls   (cls),
        .cond  (instr[10:8]),
        .ccr   (ccr_q),
        .taken (br_taken)
    );

    assign ccr_upd = (cls == CL_ALU) || (cls == CL_CMP) ||
                     (cls == CL_ADDI) || (cls == CL_SUBI);
    assign wb_reg  = (cls == CL_ALU) || (cls == CL_LW) || (cls == CL_LI) ||
                     (cls == CL_ADDI) || (cls == CL_SUBI) || (cls == CL_IN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ccr_q     <= 4'b0000;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ccr_q     <= ccr_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ccr_d     = ccr_q;
        retired_d = retired_q;
        phase     = 5'b00000;
        ir_we     = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        reg_we    = 1'b0;
        out_we    = 1'b0;
        halted    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_P1;
            end
            ST_P1: begin
                phase  = 5'b00001;
                mem_re = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = ST_P2;
                end
            end
            ST_P2: begin
                phase   = 5'b00010;
                state_d = ST_P3;
            end
            ST_P3: begin
                phase = 5'b00100;
                if (ccr_upd) ccr_d = code;
`ifdef SKIP_P4_EN
                if ((cls == CL_LW) || (cls == CL_ST) || (cls == CL_B) || (cls == CL_BCC))
                    state_d = ST_P4;
                else
                    state_d = ST_P5;
`else
                state_d = ST_P4;
`endif
            end
            ST_P4: begin
                phase   = 5'b01000;
                state_d = ST_P5;
                if (cls == CL_LW || cls == CL_ST) begin
                    mem_re = (cls == CL_LW);
                    mem_we = (cls == CL_ST);
                    if (!mem_ready) state_d = ST_P4;
                end
                pc_load = br_taken;
            end
            ST_P5: begin
                phase     = 5'b10000;
                reg_we    = wb_reg;
                out_we    = (cls == CL_OUT);
                retired_d = retired_q + RET_W'(1);
                state_d   = (cls == CL_HLT) ? ST_HALT : ST_P1;
            end
            ST_HALT: begin
                halted = 1'b1;
                if (start) state_d = ST_P1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign running = (phase != 5'b00000);
    assign ccr     = ccr_q;
    assign retired = retired_q;

endmodule

// File: doc/simple_phase_ctrl.md
Name: simple_phase_ctrl

Overview:
- Multicycle sequencer for the 16-bit processor core: steps each instruction through phases P1..P5 and drives the strobes for the IR, PC, register file, memory, I/O and condition-code register (CCR).
- Holds the architectural CCR {S,Z,C,V}, latched from the calc unit's `code` output.
- Resolves conditional branches, stalls on memory wait, and handles HLT / restart.

Parameters:
- RET_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- start  in  1  run pulse; honoured only in IDLE or HALT
- instr  in  16  IR contents; stable from P2 until next P1
- code  in  4  calc flags {S,Z,C,V}
- mem_ready  in  1  memory access completes this cycle
- phase  out  5  one-hot {P5,P4,P3,P2,P1}; all zero in IDLE/HALT
- ir_we  out  1  load IR from memory data
- pc_inc  out  1  PC <= PC+1
- pc_load  out  1  PC <= branch target
- mem_re  out  1  memory read (fetch or LW)
- mem_we  out  1  memory write (ST)
- reg_we  out  1  register-file write
- out_we  out  1  output-port latch (OUT)
- ccr  out  4  current CCR {S,Z,C,V}
- running  out  1  in P1..P5
- halted  out  1  in HALT
- retired  out  RET_W  retired-instruction count

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state IDLE, ccr 0, retired 0, all strobes 0, phase 0.
- Strobe timing:
  - All strobes are combinational from the registered state plus instr.
  - Each strobe's action takes effect at the rising edge that ends the cycle.
- Decode classes:
  - ALU: instr[15:14]=11 with op3=instr[7:4] in 0000..1011.
  - IN: op3 1100. OUT: op3 1101. HLT: op3 1111.
  - LW: 00. ST: 01.
  - LI: 10000. ADDI: 10001. SUBI: 10010.
  - B: 10100. Bcc: 10111, cond=instr[10:8]: 000 BE, 001 BLT, 010 BLE, 011 BNE.
  - Anything else is a NOP.
- States: IDLE, P1, P2, P3, P4, P5, HALT.
- IDLE: start=1 -> P1.
- P1 (fetch):
  - mem_re=1.
  - mem_ready=0: stay in P1.
  - mem_ready=1: ir_we=1, pc_inc=1, -> P2.
- P2 (decode/read): -> P3.
- P3 (execute):
  - CCR <= code for ALU except op3 0101..? — no: CCR <= code for ALU (including CMP), ADDI and SUBI.
  - No CCR update for LW, ST, LI, IN, OUT, HLT, branches or NOP.
  - -> P4.
- P4 (memory/branch):
  - LW: mem_re=1. ST: mem_we=1. Both stay in P4 until mem_ready=1.
  - Branches: pc_load=1 if taken, using the CCR value at P4 entry.
  - Taken conditions: B always; BE Z; BLT S^V; BLE Z|(S^V); BNE !Z; Bcc cond 1xx never.
  - All other classes: single cycle, -> P5.
- P5 (writeback):
  - reg_we=1 for ALU except CMP (0101), and for LW, LI, ADDI, SUBI, IN.
  - out_we=1 for OUT.
  - retired increments and wraps at 2^RET_W.
  - HLT -> HALT; otherwise -> P1.
- HALT: halted=1. start=1 -> P1 (resume at current PC). ccr and retired are held.
- start outside IDLE/HALT is ignored.
- mem_ready outside P1 and LW/ST P4 is ignored.
- rst_n low in any state returns immediately to IDLE with all strobes deasserted; the partial instruction is discarded.

Optional Feature:
- SKIP_P4_EN defined:
  - Classes with no memory access and no branch go P3 -> P5 directly; P4 is never visited for them.
  - CPI is 4 for these instructions, 5+ for LW/ST/branches.
- SKIP_P4_EN undefined: every instruction visits all five phases.

Decomposition:
- Shared package `simple_pkg` holds:
  - state encoding
  - op3 constants (ADD..SRA, IN, OUT, HLT)
  - op2/opcode constants (LW, ST, LI, ADDI, SUBI, B, BCC)
  - cond constants (BE, BLT, BLE, BNE)
  - CCR bit indices
- One sub-module, `simple_br_eval` (combinational): takes cond, class and ccr; returns taken.

Test Plan:
- Reset, start pulse, instr=ADD (0xC000), mem_ready=1, code=0100 -> phase walks P1..P5, CCR=0100 after P3, reg_we in P5, retired=1.
- CMP then BE (0xB802), code Z=1 -> reg_we=0 on CMP; pc_load=1 in BE's P4. Repeat with Z=0 -> pc_load=0.
- BLT with S=1, V=0 -> taken; BLE with S=1, V=1, Z=0 -> not taken.
- LW with mem_ready low 3 cycles in P4 -> stays in P4 with mem_re=1 for 4 cycles, then P5 with reg_we=1. Fetch stall in P1 behaves the same with pc_inc only on the ready cycle.
- HLT (0xC0F0) -> halted=1, phase=0; start -> P1. rst_n pulsed mid-P3 -> IDLE, ccr=0, retired=0.
- With SKIP_P4_EN: ADD retires in 4 cycles, ST still in 5. retired wraps 0xFFFF -> 0x0000.
